pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Parametrised pipeline-boundary register. It is the common building block for every inter-stage register of the pipelined datapath (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Generalises the fixed-width, always-load stage registers.
- Configurable payload and control widths, and DEPTH chained stages.
- Adds a per-stage valid bit, stall (hold), flush (bubble insertion with control zeroing), and saturating stall/flush event counters for performance debug.

Parameters:
DATA_W, 32, payload width (PC, instruction, ALU result, read data, register address etc. concatenated by the instantiator)
CTRL_W, 8, control-flag width (regWrite, memRead, memWrite, branch...); forced to 0 on bubbles and flushes
DEPTH, 1, number of chained register stages; legal 1..4, anything else is an elaboration error
CNT_W, 16, width of the stall and flush event counters

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
stall_in  in  1  hold all stages this cycle
flush_in  in  1  invalidate all stages this cycle (overrides stall_in)
clr_cnt_in  in  1  synchronous clear of both event counters
valid_in  in  1  upstream payload is a real instruction
ctrl_in  in  CTRL_W  upstream control flags
data_in  in  DATA_W  upstream payload
valid_out  out  1  valid bit of last stage
ctrl_out  out  CTRL_W  control flags of last stage
data_out  out  DATA_W  payload of last stage
stall_cnt_out  out  CNT_W  cycles with effective stall
flush_cnt_out  out  CNT_W  cycles with flush

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst).
- State per stage i (0..DEPTH-1): v[i], c[i], d[i]. Outputs are driven directly from stage DEPTH-1 registers; no combinational path from inputs to outputs.
- Reset (asserted at any time, including mid-stall or mid-flush): every v, c, d and both counters go to 0 immediately.
  - After rst deasserts, valid_out=0, ctrl_out=0, data_out=0, stall_cnt_out=0, flush_cnt_out=0 until new data propagates.
- Per-cycle priority: rst > flush_in > stall_in > advance.
- flush_in=1:
  - All v[i]<=0 and c[i]<=0; all d[i] hold their value.
  - Inputs are discarded that cycle.
  - stall_in is ignored.
- stall_in=1 and flush_in=0: every stage holds v, c, d unchanged; inputs are discarded.
- Advance (stall_in=0, flush_in=0):
  - Stage 0 loads v[0]<=valid_in, c[0]<=valid_in ? ctrl_in : 0, d[0]<=data_in.
  - Stage i>0 loads stage i-1 unchanged.
  - Control is gated so an invalid slot can never carry a write-enable.
- Latency: without stall or flush, an input sampled at edge N appears on the outputs after edge N+DEPTH-1 (DEPTH=1 matches the classic single-register stage).
- Invariant: c[i]==0 whenever v[i]==0.
- stall_cnt:
  - Increments by 1 on each edge where stall_in=1 and flush_in=0.
  - Saturates at 2^CNT_W-1; no wrap-around.
- flush_cnt: increments on each edge where flush_in=1; saturates likewise.
- clr_cnt_in=1 sets both counters to 0 at the edge, taking priority over increment. It does not affect pipeline state.
- stall_in/flush_in with all stages invalid behave identically: no special-casing.

Test Plan:
- Reset with DEPTH=1, no stimulus → after rst deasserts, all outputs 0.
- Reset asserted mid-stream: drive 3 valid words, assert rst asynchronously between edges → outputs 0 immediately, before the next edge.
- Streaming, DEPTH=3: valid_in=1, data_in=0x100,0x104,0x108, ctrl_in=0x05, no stall → 0x100 with ctrl 0x05 visible after the 3rd edge, then one word per cycle; valid_out stays 1.
- Bubble gating, DEPTH=1: valid_in=0, ctrl_in=0xFF, data_in=0xDEAD → valid_out=0, ctrl_out=0x00, data_out=0xDEAD.
- Stall, DEPTH=2: hold stall_in=1 for 4 cycles mid-stream with data 0xA,0xB in flight → outputs frozen at 0xA for 4 cycles, then 0xB; stall_cnt_out=4.
- Flush with simultaneous stall: DEPTH=2 full of valid ctrl=0x3 words, assert flush_in=1 and stall_in=1 together → next cycle valid_out=0, ctrl_out=0, data held; flush_cnt_out=1, stall_cnt_out unchanged.
- Counter saturation: CNT_W=4, stall 20 cycles → stall_cnt_out stops at 15.
- Counter clear: pulse clr_cnt_in together with stall_in → stall_cnt_out=0 at that edge.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline-boundary register: DEPTH chained stages carrying valid/ctrl/data,
// with stall hold, flush bubble insertion and saturating stall/flush event counters.
module pipe_stage_reg #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 8,
   parameter int DEPTH  = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_in,
   input  logic              flush_in,
   input  logic              clr_cnt_in,
   input  logic              valid_in,
   input  logic [CTRL_W-1:0] ctrl_in,
   input  logic [DATA_W-1:0] data_in,
   output logic              valid_out,
   output logic [CTRL_W-1:0] ctrl_out,
   output logic [DATA_W-1:0] data_out,
   output logic [CNT_W-1:0]  stall_cnt_out,
   output logic [CNT_W-1:0]  flush_cnt_out
);

   generate
      if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
         $error("pipe_stage_reg: DEPTH must be in 1..4");
      end
   endgenerate

   logic [DEPTH-1:0]  v_q, v_d;
   logic [CTRL_W-1:0] c_q [DEPTH];
   logic [CTRL_W-1:0] c_d [DEPTH];
   logic [DATA_W-1:0] d_q [DEPTH];
   logic [DATA_W-1:0] d_d [DEPTH];
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
   logic              advance;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
      return (&x) ? x : x + CNT_W'(1);
   endfunction

   assign advance = !stall_in && !flush_in;

   always_comb begin
      v_d = v_q;
      for (int i = 0; i < DEPTH; i++) begin
         c_d[i] = c_q[i];
         d_d[i] = d_q[i];
      end
      if (flush_in) begin
         // Bubbles keep their payload; only valid and control are cleared.
         v_d = '0;
         for (int i = 0; i < DEPTH; i++) begin
            c_d[i] = '0;
         end
      end else if (advance) begin
         v_d[0] = valid_in;
         c_d[0] = valid_in ? ctrl_in : '0;
         d_d[0] = data_in;
         for (int i = 1; i < DEPTH; i++) begin
            v_d[i] = v_q[i-1];
            c_d[i] = c_q[i-1];
            d_d[i] = d_q[i-1];
         end
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (clr_cnt_in) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
      end else begin
         if (stall_in && !flush_in) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
         end
         if (flush_in) begin
            flush_cnt_d = sat_inc(flush_cnt_q);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q         <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            c_q[i] <= '0;
            d_q[i] <= '0;
         end
      end else begin
         v_q         <= v_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         for (int i = 0; i < DEPTH; i++) begin
            c_q[i] <= c_d[i];
            d_q[i] <= d_d[i];
         end
      end
   end

   assign valid_out     = v_q[DEPTH-1];
   assign ctrl_out      = c_q[DEPTH-1];
   assign data_out      = d_q[DEPTH-1];
   assign stall_cnt_out = stall_cnt_q;
   assign flush_cnt_out = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a queue-based reference pipeline predicts every
// cycle's outputs; a separate negedge monitor pops and compares them.
module tb_pipe_stage_reg;
   localparam int DW   = 32;
   localparam int CW   = 8;
   localparam int DP   = 3;
   localparam int NW   = 4;
   localparam int CMAX = (1 << NW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          stall_in = 1'b0, flush_in = 1'b0, clr_cnt_in = 1'b0, valid_in = 1'b0;
   logic [CW-1:0] ctrl_in = '0;
   logic [DW-1:0] data_in = '0;
   logic          valid_out;
   logic [CW-1:0] ctrl_out;
   logic [DW-1:0] data_out;
   logic [NW-1:0] stall_cnt_out, flush_cnt_out;

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(DP), .CNT_W(NW)) dut (
      .clk(clk), .rst(rst), .stall_in(stall_in), .flush_in(flush_in),
      .clr_cnt_in(clr_cnt_in), .valid_in(valid_in), .ctrl_in(ctrl_in),
      .data_in(data_in), .valid_out(valid_out), .ctrl_out(ctrl_out),
      .data_out(data_out), .stall_cnt_out(stall_cnt_out),
      .flush_cnt_out(flush_cnt_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit            v;
      logic [CW-1:0] c;
      logic [DW-1:0] d;
   } slot_t;

   typedef struct {
      slot_t o;
      int    sc;
      int    fc;
   } exp_t;

   slot_t pipe[$];
   exp_t  expq[$];
   int    m_sc = 0, m_fc = 0;
   int    checks = 0, errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_model();
      slot_t z;
      z.v = 1'b0; z.c = '0; z.d = '0;
      pipe.delete();
      for (int i = 0; i < DP; i++) pipe.push_back(z);
      m_sc = 0;
      m_fc = 0;
   endtask

   // Reference behaviour at one rising edge, from the inputs currently applied.
   task automatic model_edge();
      slot_t n;
      exp_t  e;
      if (rst) begin
         clear_model();
      end else begin
         if (clr_cnt_in) begin
            m_sc = 0;
            m_fc = 0;
         end else begin
            if (stall_in && !flush_in) m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
            if (flush_in) m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
         end
         if (flush_in) begin
            foreach (pipe[i]) begin
               pipe[i].v = 1'b0;
               pipe[i].c = '0;
            end
         end else if (!stall_in) begin
            n.v = valid_in;
            n.c = valid_in ? ctrl_in : '0;
            n.d = data_in;
            pipe.push_front(n);
            void'(pipe.pop_back());
         end
      end
      e.o  = pipe[DP-1];
      e.sc = m_sc;
      e.fc = m_fc;
      expq.push_back(e);
   endtask

   task automatic step(input bit s, input bit f, input bit cl, input bit vi,
                       input logic [CW-1:0] c, input logic [DW-1:0] d);
      stall_in   = s;
      flush_in   = f;
      clr_cnt_in = cl;
      valid_in   = vi;
      ctrl_in    = c;
      data_in    = d;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("valid_out", 64'(valid_out), 64'(e.o.v));
            chk("ctrl_out", 64'(ctrl_out), 64'(e.o.c));
            chk("data_out", 64'(data_out), 64'(e.o.d));
            chk("stall_cnt", 64'(stall_cnt_out), 64'(e.sc));
            chk("flush_cnt", 64'(flush_cnt_out), 64'(e.fc));
         end
      end
   end

   initial begin : driver
      clear_model();
      step(0, 0, 0, 0, '0, '0);
      step(0, 0, 0, 0, '0, '0);
      rst = 1'b0;
      step(0, 0, 0, 0, '0, '0);

      // Streaming words, then a bubble carrying ctrl that must be gated.
      step(0, 0, 0, 1, 8'h05, 32'h100);
      step(0, 0, 0, 1, 8'h05, 32'h104);
      step(0, 0, 0, 1, 8'h05, 32'h108);
      step(0, 0, 0, 0, 8'hFF, 32'hDEAD);
      for (int i = 0; i < DP; i++) step(0, 0, 0, 0, 8'hFF, 32'hDEAD);

      // Stall mid-stream.
      step(0, 0, 0, 1, 8'h11, 32'hA);
      step(0, 0, 0, 1, 8'h12, 32'hB);
      step(0, 0, 0, 1, 8'h13, 32'hC);
      for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 8'h77, 32'h777);
      step(0, 0, 0, 1, 8'h14, 32'hD);
      step(0, 0, 0, 1, 8'h15, 32'hE);

      // Full pipe of ctrl=0x3 words, then flush together with stall.
      for (int i = 0; i < DP; i++) step(0, 0, 0, 1, 8'h03, 32'h300 + i);
      step(1, 1, 0, 1, 8'h03, 32'h999);
      step(0, 0, 0, 0, '0, '0);

      // Randomised traffic.
      for (int i = 0; i < 300; i++) begin
         step($urandom_range(0, 9) < 2, $urandom_range(0, 19) == 0,
              $urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0,
              CW'($urandom), DW'($urandom));
      end

      // Counter saturation and clear-with-stall.
      step(0, 0, 1, 0, '0, '0);
      for (int i = 0; i < 20; i++) step(1, 0, 0, 1, 8'h01, 32'h5A5A);
      step(1, 0, 1, 1, 8'h01, 32'h5A5A);
      step(0, 1, 0, 0, '0, '0);

      // Asynchronous reset between edges with valid words in flight.
      step(0, 0, 0, 1, 8'h21, 32'h1001);
      step(0, 0, 0, 1, 8'h22, 32'h1002);
      step(0, 0, 0, 1, 8'h23, 32'h1003);
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("async_rst_valid", 64'(valid_out), 64'd0);
      chk("async_rst_ctrl", 64'(ctrl_out), 64'd0);
      chk("async_rst_data", 64'(data_out), 64'd0);
      chk("async_rst_scnt", 64'(stall_cnt_out), 64'd0);
      chk("async_rst_fcnt", 64'(flush_cnt_out), 64'd0);
      step(0, 0, 0, 1, 8'h24, 32'h1004);
      rst = 1'b0;
      step(0, 0, 0, 0, '0, '0);
      step(0, 0, 0, 1, 8'h25, 32'h1005);
      for (int i = 0; i < DP; i++) step(0, 0, 0, 0, '0, '0);

      @(negedge clk);
      #1;
      chk("scoreboard_drained", 64'(expq.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
